// File: rtl/avr_io_intc.sv
// IO-mapped interrupt controller: latches requests, masks them and resolves a fixed-priority vector.
// Latency: pending updates at the edge after a request; iflag/ivect follow one edge later.
// Backpressure: none; bus reads are combinational and writes complete in one cycle.
module avr_io_intc #(
  parameter int VECT_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  io_re,
  input  logic                  io_we,
  input  logic [1:0]            io_a,
  output logic [7:0]            io_do,
  input  logic [7:0]            io_di,
  input  logic [2**VECT_WIDTH-1:0] irq_in,
  output logic                  iflag,
  output logic [VECT_WIDTH-1:0] ivect
);

  localparam int NSRC = 2**VECT_WIDTH;

  localparam logic [1:0] A_IFR = 2'd0;
  localparam logic [1:0] A_IMR = 2'd1;
  localparam logic [1:0] A_ICR = 2'd2;
  localparam logic [1:0] A_ISR = 2'd3;

  // Architectural state
  logic [NSRC-1:0]       pending_q, pending_d;
  logic [NSRC-1:0]       prev_q,    prev_d;
  logic [NSRC-1:0]       imr_q,     imr_d;
  logic [NSRC-1:0]       icr_q,     icr_d;
  logic                  iflag_q,   iflag_d;
  logic [VECT_WIDTH-1:0] ivect_q,   ivect_d;

  // Decoded write strobes and working signals
  logic            wr_ifr;
  logic            wr_imr;
  logic            wr_icr;
  logic            wr_isr;
  logic [NSRC-1:0] wdata;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] edge_set;
  logic [NSRC-1:0] edge_clr;
  logic [NSRC-1:0] active;
  logic [2:0]      ivect_ext;

  // Write data bits at or above NSRC have no register behind them.
  logic unused_di;
  assign unused_di = ^io_di;

  assign wdata  = io_di[NSRC-1:0];
  assign wr_ifr = io_we && (io_a == A_IFR);
  assign wr_imr = io_we && (io_a == A_IMR);
  assign wr_icr = io_we && (io_a == A_ICR);
  assign wr_isr = io_we && (io_a == A_ISR);

  // Rising-edge detect against last cycle's request lines; prev resets to 0
  // so a line held high across reset release still registers as an edge.
  always_comb begin
    rise     = irq_in & ~prev_q;
    edge_set = rise | (wr_isr ? wdata : '0);
    edge_clr = wr_ifr ? wdata : '0;
    prev_d   = irq_in;
  end

  // Pending: level sources mirror the line, edge sources latch with set over clear.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NSRC; i++) begin
      if (!icr_q[i]) begin
        pending_d[i] = irq_in[i];
      end else if (edge_set[i]) begin
        pending_d[i] = 1'b1;
      end else if (edge_clr[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Mask and mode registers take the low NSRC bits of a write.
  always_comb begin
    imr_d = imr_q;
    icr_d = icr_q;
    if (wr_imr) begin
      imr_d = wdata;
    end
    if (wr_icr) begin
      icr_d = wdata;
    end
  end

  // Fixed-priority resolve from registered pending/mask; bit 0 wins, vector holds when idle.
  always_comb begin
    active  = pending_q & imr_q;
    iflag_d = |active;
    ivect_d = ivect_q;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        ivect_d = VECT_WIDTH'(i);
      end
    end
  end

  // All state resets synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      prev_q    <= '0;
      imr_q     <= '0;
      icr_q     <= '0;
      iflag_q   <= 1'b0;
      ivect_q   <= '0;
    end else begin
      pending_q <= pending_d;
      prev_q    <= prev_d;
      imr_q     <= imr_d;
      icr_q     <= icr_d;
      iflag_q   <= iflag_d;
      ivect_q   <= ivect_d;
    end
  end

  assign ivect_ext = 3'(ivect_q);

  // Read mux drives zero when not selected so the bus can be OR-merged.
  always_comb begin
    io_do = 8'h00;
    if (io_re) begin
      unique case (io_a)
        A_IFR:   io_do = 8'(pending_q);
        A_IMR:   io_do = 8'(imr_q);
        A_ICR:   io_do = 8'(icr_q);
        A_ISR:   io_do = {iflag_q, 4'b0000, ivect_ext};
        default: io_do = 8'h00;
      endcase
    end
  end

  assign iflag = iflag_q;
  assign ivect = ivect_q;

endmodule

// File: tb/tb_avr_io_intc.sv
module tb_avr_io_intc;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_re;
  logic       io_we;
  logic [1:0] io_a;
  logic [7:0] io_do;
  logic [7:0] io_di;
  logic [3:0] irq_in;
  logic       iflag;
  logic [1:0] ivect;

  int checks = 0;
  int errors = 0;

  avr_io_intc #(.VECT_WIDTH(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_re  (io_re),
    .io_we  (io_we),
    .io_a   (io_a),
    .io_do  (io_do),
    .io_di  (io_di),
    .irq_in (irq_in),
    .iflag  (iflag),
    .ivect  (ivect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_we = 1'b1;
    io_a  = a;
    io_di = d;
    tick();
    io_we = 1'b0;
    io_di = 8'h00;
    io_a  = 2'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    io_re = 1'b1;
    io_a  = a;
    #1;
    chk(tag, io_do, exp);
    io_re = 1'b0;
    io_a  = 2'd0;
  endtask

  task automatic chk_flag(input logic f, input logic [1:0] v, input string tag);
    chk({tag, "_iflag"}, {7'b0, iflag}, {7'b0, f});
    chk({tag, "_ivect"}, {6'b0, ivect}, {6'b0, v});
  endtask

  initial begin
    rst    = 1'b1;
    io_re  = 1'b0;
    io_we  = 1'b0;
    io_a   = 2'd0;
    io_di  = 8'h00;
    irq_in = 4'hF;

    // Reset with all requests high
    tick();
    tick();
    rd(2'd0, 8'h00, "rst_ifr");
    rd(2'd1, 8'h00, "rst_imr");
    rd(2'd2, 8'h00, "rst_icr");
    chk_flag(1'b0, 2'd0, "rst");
    irq_in = 4'h0;
    rst    = 1'b0;
    tick();

    // Edge latch on source 2
    wr(2'd2, 8'h0F);
    wr(2'd1, 8'h0F);
    rd(2'd2, 8'h0F, "icr_rb");
    rd(2'd1, 8'h0F, "imr_rb");
    irq_in = 4'h4;
    tick();
    irq_in = 4'h0;
    rd(2'd0, 8'h04, "edge_ifr");
    chk_flag(1'b0, 2'd0, "edge_n");
    tick();
    chk_flag(1'b1, 2'd2, "edge_n1");
    wr(2'd0, 8'h04);
    rd(2'd0, 8'h00, "w1c_ifr");
    tick();
    chk_flag(1'b0, 2'd2, "w1c");

    // Priority between sources 3 and 1
    irq_in = 4'hA;
    tick();
    irq_in = 4'h0;
    rd(2'd0, 8'h0A, "prio_ifr");
    tick();
    chk_flag(1'b1, 2'd1, "prio_a");
    wr(2'd0, 8'h02);
    tick();
    chk_flag(1'b1, 2'd3, "prio_b");
    wr(2'd0, 8'h08);
    tick();
    chk_flag(1'b0, 2'd3, "prio_c");

    // Level mode on source 0
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h01);
    irq_in = 4'h1;
    tick();
    tick();
    chk_flag(1'b1, 2'd0, "lvl_on");
    wr(2'd0, 8'h01);
    tick();
    rd(2'd0, 8'h01, "lvl_w1c_ifr");
    chk_flag(1'b1, 2'd0, "lvl_w1c");
    irq_in = 4'h0;
    tick();
    chk({"lvl_drop1"}, {7'b0, iflag}, 8'h01);
    tick();
    chk({"lvl_drop2"}, {7'b0, iflag}, 8'h00);

    // Masked software interrupt, then unmask
    wr(2'd2, 8'h0F);
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h08);
    rd(2'd0, 8'h08, "sw_ifr");
    tick();
    chk({"sw_masked"}, {7'b0, iflag}, 8'h00);
    wr(2'd1, 8'h08);
    tick();
    chk_flag(1'b1, 2'd3, "sw_unmask");
    rd(2'd3, 8'h83, "isr_rd");

    // No read strobe: bus stays quiet whatever the address
    for (int a = 0; a < 4; a++) begin
      io_a = 2'(a);
      #1;
      chk("bus_idle", io_do, 8'h00);
    end
    io_a = 2'd0;

    // Rising edge and W1C on the same source in the same cycle
    wr(2'd0, 8'h08);
    rd(2'd0, 8'h00, "coll_pre");
    irq_in = 4'h1;
    wr(2'd0, 8'h01);
    rd(2'd0, 8'h01, "coll_ifr");
    irq_in = 4'h0;

    // Reset mid-run clears everything
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(2'd0, 8'h00, "rst2_ifr");
    rd(2'd1, 8'h00, "rst2_imr");
    rd(2'd2, 8'h00, "rst2_icr");
    chk_flag(1'b0, 2'd0, "rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avr_io_intc.md
Name: avr_io_intc

Overview:
- IO-mapped interrupt controller that replaces the fixed combinational priority encoder between peripheral IRQ lines and the core's iflag/ivect inputs.
- Latches edge-triggered requests, applies a per-source enable mask, supports software-raised interrupts, and resolves a fixed-priority vector.
- Occupies a 4-register window on the AVR IO bus. Top-level decode supplies io_re/io_we already qualified by the select.

Parameters:
- VECT_WIDTH, 2, width of ivect. Source count NSRC = 2**VECT_WIDTH. Legal values 1..3, so NSRC is at most 8.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- io_re  input  1  read strobe, pre-qualified by address select
- io_we  input  1  write strobe, pre-qualified by address select
- io_a  input  2  register select
- io_do  output  8  read data to core
- io_di  input  8  write data from core
- irq_in  input  NSRC  peripheral request lines, clk domain, active-high
- iflag  output  1  interrupt request to core
- ivect  output  VECT_WIDTH  vector index to core

Behaviour:
- Registers, selected by io_a:
  - 0 IFR: pending[NSRC-1:0]; read returns pending. Write is W1C: each 1 clears that bit in edge mode.
  - 1 IMR: mask, read/write, reset 0x00.
  - 2 ICR: mode per source, read/write, reset 0x00. 0 = level, 1 = edge.
  - 3 ISR: read returns {iflag, 4'b0, ivect zero-extended to 3 bits}. Write sets pending bits: software interrupt, edge-mode sources only.
- Bits at or above NSRC read 0 and ignore writes.
- io_do is combinational: selected register when io_re=1, else 8'h00, so it can be OR-merged on the shared bus.
- Writes take effect at the rising edge where io_we=1.
- Edge detect:
  - prev[i] register, reset 0; updated every cycle: prev <= irq_in.
  - Edge mode: pending[i] <= 1 when irq_in[i] & ~prev[i], or on an ISR write with bit i = 1.
  - Edge mode: pending[i] cleared by an IFR write with bit i = 1.
  - Set and clear in the same cycle: set wins.
- Level mode: pending[i] <= irq_in[i] every cycle. W1C and ISR writes have no effect.
- Mode change from edge to level: pending follows irq_in from the next edge.
- Mode change from level to edge: pending holds its current value and is then W1C-managed.
- Resolution:
  - active = pending & IMR.
  - iflag <= |active (registered).
  - ivect <= index of the lowest set bit of active (bit 0 = highest priority), registered.
  - ivect holds its last value when active = 0.
- Latency:
  - Edge-mode irq rises before edge N: pending set at edge N, iflag/ivect valid after edge N+1.
  - W1C at edge M: iflag drops after edge M+1, if no other active bit.
- Reset (synchronous, any time): pending, prev, IMR, ICR, iflag and ivect all 0.
- An irq_in held high through reset release counts as a rising edge; in edge mode it sets pending at the first edge after rst deasserts.
- Changing IMR never alters pending. Masked requests stay latched and raise iflag when unmasked.

Test Plan:
- Reset: rst=1 for 2 cycles with irq_in=4'hF. Required: IFR, IMR, ICR, iflag and ivect read 0 during reset.
- Edge latch (VECT_WIDTH=2): write ICR=0x0F and IMR=0x0F, then pulse irq_in[2] for 1 cycle.
  - Required: IFR=0x04; iflag=1 and ivect=2 two edges after the pulse.
  - Then write IFR=0x04. Required: IFR=0x00 and iflag=0 one edge later.
- Priority: edge mode with all sources enabled; pulse irq_in[3] and irq_in[1] together.
  - Required: ivect=1. After W1C 0x02, ivect=3.
  - After W1C 0x08, iflag=0 and ivect stays 3.
- Level mode: ICR=0x00, IMR=0x01, hold irq_in[0]=1.
  - Required: iflag=1. A W1C of 0x01 does not clear it. Drop irq_in[0]; iflag=0 two edges later.
- Mask/software:
  - Edge mode, IMR=0x00; write ISR=0x08. Required: IFR=0x08, iflag=0.
  - Then write IMR=0x08. Required: iflag=1, ivect=3.
  - ISR read returns 0x83.
- Set/clear collision: in edge mode, a rising edge on irq_in[0] in the same cycle as a W1C of 0x01. Required: IFR bit 0 = 1.
- Bus read: with io_re=0 and any io_a, io_do=0x00.
